// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath/IR/memory.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             alu_zero;
    logic             mem_ready;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic             alu_src_b;
    logic [2:0]       alu_ctrl;
    logic             mem_re;
    logic             mem_we;
    logic             reg_we;
    logic             reg_dst;
    logic             mem_to_reg;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, opcode, funct, alu_zero, mem_ready,
        output ir_we, pc_we, pc_src, alu_src_b, alu_ctrl, mem_re, mem_we,
               reg_we, reg_dst, mem_to_reg, state, illegal, retired
    );

    modport slave (
        output run, opcode, funct, alu_zero, mem_ready,
        input  ir_we, pc_we, pc_src, alu_src_b, alu_ctrl, mem_re, mem_we,
               reg_we, reg_dst, mem_to_reg, state, illegal, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for a small MIPS-like subset (R-type add/sub/and/or, lw, sw, beq).
// Control outputs are decoded from the state register and the opcode/funct latched in DECODE.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'b000,
        ST_DECODE = 3'b001,
        ST_EXEC   = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB     = 3'b100,
        ST_HALT   = 3'b101
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    function automatic logic funct_ok(input logic [5:0] fn);
        logic ok;
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic insn_ok(input logic [5:0] opc, input logic [5:0] fn);
        logic ok;
        case (opc)
            OP_RTYPE:             ok = funct_ok(fn);
            OP_LW, OP_SW, OP_BEQ: ok = 1'b1;
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_e           state_q,   state_d;
    logic [5:0]       opcode_q,  opcode_d;
    logic [5:0]       funct_q,   funct_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       ir_we_s;
    logic       pc_we_s;
    logic       pc_src_s;
    logic       alu_src_b_s;
    logic [2:0] alu_ctrl_s;
    logic       mem_re_s;
    logic       mem_we_s;
    logic       reg_we_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       retire_s;

    // State register and latched instruction fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            opcode_q  <= 6'b000000;
            funct_q   <= 6'b000000;
            illegal_q <= 1'b0;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            funct_q   <= funct_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        funct_d      = funct_q;
        illegal_d    = illegal_q;
        ir_we_s      = 1'b0;
        pc_we_s      = 1'b0;
        pc_src_s     = 1'b0;
        alu_src_b_s  = 1'b0;
        alu_ctrl_s   = ALU_ADD;
        mem_re_s     = 1'b0;
        mem_we_s     = 1'b0;
        reg_we_s     = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        retire_s     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // ir_we is the fetch strobe itself, so it alone follows run
                if (bus.run) begin
                    ir_we_s = ~rst;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end

            ST_DECODE: begin
                opcode_d = bus.opcode;
                funct_d  = bus.funct;
                if (insn_ok(bus.opcode, bus.funct)) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end

            ST_EXEC: begin
                case (opcode_q)
                    OP_RTYPE: begin
                        alu_ctrl_s = funct_alu(funct_q);
                        state_d    = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b_s = 1'b1;
                        alu_ctrl_s  = ALU_ADD;
                        state_d     = ST_MEM;
                    end
                    OP_BEQ: begin
                        alu_ctrl_s = ALU_SUB;
                        pc_we_s    = 1'b1;
                        pc_src_s   = bus.alu_zero;
                        retire_s   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_HALT;
                    end
                endcase
            end

            ST_MEM: begin
                // A wait cycle (mem_ready low) keeps the request up and nothing else
                if (opcode_q == OP_LW) begin
                    mem_re_s   = 1'b1;
                    alu_ctrl_s = ALU_ADD;
                    if (bus.mem_ready) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_MEM;
                    end
                end else if (opcode_q == OP_SW) begin
                    mem_we_s = 1'b1;
                    if (bus.mem_ready) begin
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_MEM;
                    end
                end else begin
                    state_d = ST_HALT;
                end
            end

            ST_WB: begin
                if (opcode_q == OP_RTYPE) begin
                    reg_we_s  = 1'b1;
                    reg_dst_s = 1'b1;
                    pc_we_s   = 1'b1;
                    retire_s  = 1'b1;
                    state_d   = ST_FETCH;
                end else if (opcode_q == OP_LW) begin
                    reg_we_s     = 1'b1;
                    mem_to_reg_s = 1'b1;
                    pc_we_s      = 1'b1;
                    retire_s     = 1'b1;
                    state_d      = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase

        retired_d = retired_q + CNT_W'(retire_s);
    end

    assign bus.ir_we      = ir_we_s;
    assign bus.pc_we      = pc_we_s;
    assign bus.pc_src     = pc_src_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.alu_ctrl   = alu_ctrl_s;
    assign bus.mem_re     = mem_re_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.reg_we     = reg_we_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.state      = state_q;
    assign bus.illegal    = illegal_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and packed control-vector checks.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [2:0] S_F = 3'b000;
    localparam logic [2:0] S_D = 3'b001;
    localparam logic [2:0] S_E = 3'b010;
    localparam logic [2:0] S_M = 3'b011;
    localparam logic [2:0] S_W = 3'b100;
    localparam logic [2:0] S_H = 3'b101;

    // {ir_we, pc_we, pc_src, alu_src_b, alu_ctrl[2:0], mem_re, mem_we, reg_we, reg_dst, mem_to_reg}
    localparam logic [11:0] C_NONE  = 12'h000;
    localparam logic [11:0] C_FETCH = 12'h800;
    localparam logic [11:0] C_E_MEM = 12'h100;
    localparam logic [11:0] C_LW_M  = 12'h010;
    localparam logic [11:0] C_LW_WB = 12'h405;
    localparam logic [11:0] C_SW_M  = 12'h008;
    localparam logic [11:0] C_SW_MR = 12'h408;
    localparam logic [11:0] C_R_WB  = 12'h406;
    localparam logic [11:0] C_BEQ_T = 12'h620;
    localparam logic [11:0] C_BEQ_N = 12'h420;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [11:0] ctl_s;
    assign ctl_s = {bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_src_b, bus.alu_ctrl,
                    bus.mem_re, bus.mem_we, bus.reg_we, bus.reg_dst, bus.mem_to_reg};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1: check the current cycle, then move to the next posedge+1.
    task automatic cyc(input string tag, input logic [2:0] st, input logic [11:0] c);
        #1;
        check({tag, "/state"}, 32'(bus.state), 32'(st));
        check({tag, "/ctl"}, 32'(ctl_s), 32'(c));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "/rst_state"}, 32'(bus.state), 32'(S_F));
        check({tag, "/rst_illegal"}, 32'(bus.illegal), 32'd0);
        check({tag, "/rst_retired"}, 32'(bus.retired), 32'd0);
        check({tag, "/rst_ctl"}, 32'(ctl_s), 32'(C_NONE));
        @(posedge clk);
        #1;
        check({tag, "/rst_edge_ctl"}, 32'(ctl_s), 32'(C_NONE));
        check({tag, "/rst_edge_retired"}, 32'(bus.retired), 32'd0);
        rst = 1'b0;
    endtask

    logic [5:0]  fn_tab  [3] = '{6'b100000, 6'b100100, 6'b100101};
    logic [11:0] ctl_tab [3] = '{12'h000, 12'h040, 12'h060};

    initial begin
        rst           = 1'b1;
        bus.run       = 1'b1;
        bus.opcode    = 6'b000000;
        bus.funct     = 6'b000000;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b0;
        #2;
        check("reset/state", 32'(bus.state), 32'(S_F));
        check("reset/ctl", 32'(ctl_s), 32'(C_NONE));
        check("reset/illegal", 32'(bus.illegal), 32'd0);
        check("reset/retired", 32'(bus.retired), 32'd0);
        @(posedge clk);
        #1;
        check("reset_edge/state", 32'(bus.state), 32'(S_F));
        rst     = 1'b0;
        bus.run = 1'b0;
        cyc("idle0", S_F, C_NONE);
        cyc("idle1", S_F, C_NONE);

        // R-type SUB; opcode/funct scrambled after DECODE to prove they are latched
        bus.run = 1'b1; bus.opcode = 6'b000000; bus.funct = 6'b100010;
        cyc("rsub_f", S_F, C_FETCH);
        bus.run = 1'b0;
        cyc("rsub_d", S_D, C_NONE);
        bus.opcode = 6'b000010; bus.funct = 6'b000000;
        cyc("rsub_e", S_E, 12'h020);
        cyc("rsub_wb", S_W, C_R_WB);
        check("rsub/retired", 32'(bus.retired), 32'd1);
        cyc("rsub_idle", S_F, C_NONE);

        // lw with two memory wait cycles: 7 cycles total
        bus.run = 1'b1; bus.opcode = 6'b100011; bus.mem_ready = 1'b0;
        cyc("lw_f", S_F, C_FETCH);
        bus.run = 1'b0;
        cyc("lw_d", S_D, C_NONE);
        cyc("lw_e", S_E, C_E_MEM);
        cyc("lw_m0", S_M, C_LW_M);
        cyc("lw_m1", S_M, C_LW_M);
        bus.mem_ready = 1'b1;
        cyc("lw_m2", S_M, C_LW_M);
        cyc("lw_wb", S_W, C_LW_WB);
        check("lw/retired", 32'(bus.retired), 32'd2);
        cyc("lw_idle", S_F, C_NONE);

        // sw with memory ready
        bus.run = 1'b1; bus.opcode = 6'b101011;
        cyc("sw_f", S_F, C_FETCH);
        bus.run = 1'b0;
        cyc("sw_d", S_D, C_NONE);
        cyc("sw_e", S_E, C_E_MEM);
        cyc("sw_m", S_M, C_SW_MR);
        check("sw/retired", 32'(bus.retired), 32'd3);
        cyc("sw_idle", S_F, C_NONE);

        // beq taken then not taken
        bus.run = 1'b1; bus.opcode = 6'b000100; bus.alu_zero = 1'b1;
        cyc("beqt_f", S_F, C_FETCH);
        bus.run = 1'b0;
        cyc("beqt_d", S_D, C_NONE);
        cyc("beqt_e", S_E, C_BEQ_T);
        check("beqt/retired", 32'(bus.retired), 32'd4);
        bus.run = 1'b1; bus.alu_zero = 1'b0;
        cyc("beqn_f", S_F, C_FETCH);
        bus.run = 1'b0;
        cyc("beqn_d", S_D, C_NONE);
        cyc("beqn_e", S_E, C_BEQ_N);
        check("beqn/retired", 32'(bus.retired), 32'd5);
        cyc("beq_idle", S_F, C_NONE);

        // Remaining R-type functions
        for (int i = 0; i < 3; i++) begin
            bus.run = 1'b1; bus.opcode = 6'b000000; bus.funct = fn_tab[i];
            cyc($sformatf("r%0d_f", i), S_F, C_FETCH);
            bus.run = 1'b0;
            cyc($sformatf("r%0d_d", i), S_D, C_NONE);
            cyc($sformatf("r%0d_e", i), S_E, ctl_tab[i]);
            cyc($sformatf("r%0d_wb", i), S_W, C_R_WB);
            check($sformatf("r%0d/retired", i), 32'(bus.retired), 32'(6 + i));
        end

        // Illegal opcode: HALT, sticky flag, run ignored
        bus.run = 1'b1; bus.opcode = 6'b000010;
        cyc("ill_f", S_F, C_FETCH);
        cyc("ill_d", S_D, C_NONE);
        for (int i = 0; i < 20; i++) begin
            bus.run = i[0];
            check($sformatf("ill_halt%0d/illegal", i), 32'(bus.illegal), 32'd1);
            cyc($sformatf("ill_halt%0d", i), S_H, C_NONE);
        end
        check("ill/retired_held", 32'(bus.retired), 32'd8);
        bus.run = 1'b1;
        do_reset("ill");
        bus.run = 1'b0;
        cyc("ill_post", S_F, C_NONE);

        // Illegal R-type funct
        bus.run = 1'b1; bus.opcode = 6'b000000; bus.funct = 6'b101010;
        cyc("illf_f", S_F, C_FETCH);
        cyc("illf_d", S_D, C_NONE);
        check("illf/illegal", 32'(bus.illegal), 32'd1);
        cyc("illf_h", S_H, C_NONE);
        do_reset("illf");

        // Counter wrap: 16 back-to-back sw of 4 cycles each
        bus.run = 1'b1; bus.opcode = 6'b101011; bus.mem_ready = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("wrap/retired15", 32'(bus.retired), 32'd15);
        repeat (4) @(posedge clk);
        #1;
        check("wrap/retired0", 32'(bus.retired), 32'd0);
        check("wrap/state", 32'(bus.state), 32'(S_F));

        // Reset during a MEM wait abandons the sw
        bus.opcode = 6'b000100; bus.alu_zero = 1'b0;
        cyc("pre_f", S_F, C_FETCH);
        cyc("pre_d", S_D, C_NONE);
        cyc("pre_e", S_E, C_BEQ_N);
        check("pre/retired", 32'(bus.retired), 32'd1);
        bus.opcode = 6'b101011; bus.mem_ready = 1'b0;
        cyc("swr_f", S_F, C_FETCH);
        bus.run = 1'b0;
        cyc("swr_d", S_D, C_NONE);
        cyc("swr_e", S_E, C_E_MEM);
        cyc("swr_m", S_M, C_SW_M);
        do_reset("swr");
        cyc("swr_idle", S_F, C_NONE);
        bus.run = 1'b1;
        cyc("swr_refetch", S_F, C_FETCH);
        check("swr/decode_state", 32'(bus.state), 32'(S_D));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
